// File: rtl/write_config_router.sv
// write_config_router
//   Routes a stream of register writes to NUM_CONFIGS config channels by
//   address window [ADDR_SPACE_BOUNDS[i], ADDR_SPACE_BOUNDS[i+1]). Each write
//   address is rebased to the start of its window. Each channel has its own
//   first-word-fall-through FIFO. A write that falls outside every window is
//   accepted and then discarded.
//
//   Optional feature macro: WRITE_CONFIG_ROUTER_DEBUG_EN
//     defined   : err_valid/err_addr/err_cnt record dropped writes, and a
//                 simulation assertion flags out-of-range requests.
//     undefined : the err_* outputs are tied to 0 and err_clear is ignored.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    write request handshake
//   in_addr, in_data     absolute write address and write data
//   out_valid/out_ready  per-channel handshake, one bit per channel
//   out_addr, out_data   per-channel rebased address and data, flattened;
//                        channel i is at [i*W +: W]
//   err_valid            sticky flag: at least one write was dropped
//   err_addr             address of the most recent dropped write
//   err_cnt              saturating count of dropped writes
//   err_clear            synchronous clear of the err_* outputs
module write_config_router #(
  parameter int unsigned NUM_CONFIGS = 4,
  parameter int unsigned ADDR_BITS   = 32,
  parameter int unsigned DATA_BITS   = 32,
  parameter logic [ADDR_BITS-1:0] ADDR_SPACE_BOUNDS [NUM_CONFIGS+1] =
    '{'h100, 'h200, 'h300, 'h400, 'h500},
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_BITS    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ADDR_BITS-1:0]             in_addr,
  input  logic [DATA_BITS-1:0]             in_data,
  output logic [NUM_CONFIGS-1:0]           out_valid,
  input  logic [NUM_CONFIGS-1:0]           out_ready,
  output logic [NUM_CONFIGS*ADDR_BITS-1:0] out_addr,
  output logic [NUM_CONFIGS*DATA_BITS-1:0] out_data,
  output logic                             err_valid,
  output logic [ADDR_BITS-1:0]             err_addr,
  output logic [CNT_BITS-1:0]              err_cnt,
  input  logic                             err_clear
);

  localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_BITS = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_BITS-1:0] OCC_FULL = OCC_BITS'(FIFO_DEPTH);

  logic [NUM_CONFIGS-1:0] hit;
  logic [NUM_CONFIGS-1:0] full;
  logic                   oor;
  logic                   accept;

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_CONFIGS; i++) begin
      hit[i] = (in_addr >= ADDR_SPACE_BOUNDS[i]) && (in_addr < ADDR_SPACE_BOUNDS[i+1]);
    end
  end

  assign oor = ~|hit;
  // The windows are disjoint, so (hit & full) selects the target's full flag
  // without a separate index decode. A pop in the same cycle does not make
  // room; ready depends only on registered occupancy and the address.
  assign in_ready = oor | ~|(hit & full);
  assign accept   = in_valid & in_ready;

  for (genvar g = 0; g < NUM_CONFIGS; g++) begin : g_chan
    logic [ADDR_BITS-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_data [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr;
    logic [PTR_BITS-1:0]  rd_ptr;
    logic [OCC_BITS-1:0]  occ;
    logic                 push;
    logic                 pop;

    assign push         = accept & hit[g];
    assign pop          = out_valid[g] & out_ready[g];
    assign full[g]      = (occ == OCC_FULL);
    assign out_valid[g] = (occ != '0);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
        if (push && !pop)      occ <= occ + OCC_BITS'(1);
        else if (!push && pop) occ <= occ - OCC_BITS'(1);
      end
    end

    // Storage is not reset. The output mux forces 0 while the channel is
    // empty, so stale entries are never visible.
    always_ff @(posedge clk) begin
      if (push) begin
        mem_addr[wr_ptr] <= in_addr - ADDR_SPACE_BOUNDS[g];
        mem_data[wr_ptr] <= in_data;
      end
    end

    assign out_addr[g*ADDR_BITS +: ADDR_BITS] = out_valid[g] ? mem_addr[rd_ptr] : '0;
    assign out_data[g*DATA_BITS +: DATA_BITS] = out_valid[g] ? mem_data[rd_ptr] : '0;
  end

`ifdef WRITE_CONFIG_ROUTER_DEBUG_EN
  logic drop;
  assign drop = accept & oor;

  // When a drop and err_clear occur in the same cycle, the drop is treated
  // as the first event after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_cnt   <= '0;
    end else if (drop) begin
      err_valid <= 1'b1;
      err_addr  <= in_addr;
      if (err_clear)        err_cnt <= CNT_BITS'(1);
      else if (err_cnt != '1) err_cnt <= err_cnt + CNT_BITS'(1);
    end else if (err_clear) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_cnt   <= '0;
    end
  end

`ifndef SYNTHESIS
  a_no_oor: assert property (@(posedge clk) disable iff (rst) !(in_valid && oor))
    else $error("write_config_router: out-of-range write to %h dropped", in_addr);
`endif
`else
  logic debug_unused;
  assign debug_unused = err_clear;
  assign err_valid    = 1'b0;
  assign err_addr     = '0;
  assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_write_config_router.sv
module tb_write_config_router;
  localparam int NC    = 4;
  localparam int AB    = 32;
  localparam int DB    = 32;
  localparam int DEPTH = 4;
  localparam int CB    = 2;
  localparam logic [31:0] BND [NC+1] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500};

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [AB-1:0]    in_addr;
  logic [DB-1:0]    in_data;
  logic [NC-1:0]    out_valid;
  logic [NC-1:0]    out_ready;
  logic [NC*AB-1:0] out_addr;
  logic [NC*DB-1:0] out_data;
  logic             err_valid;
  logic [AB-1:0]    err_addr;
  logic [CB-1:0]    err_cnt;
  logic             err_clear;

  always #5 clk = ~clk;

  write_config_router #(
    .NUM_CONFIGS(NC), .ADDR_BITS(AB), .DATA_BITS(DB),
    .ADDR_SPACE_BOUNDS(BND), .FIFO_DEPTH(DEPTH), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .err_valid(err_valid), .err_addr(err_addr), .err_cnt(err_cnt),
    .err_clear(err_clear)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue of {rebased addr, data} per channel, plus the error record.
  logic [63:0] q [NC][$];
  int          m_ev;
  logic [31:0] m_ea;
  int          m_ec;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int route(input logic [31:0] a);
    for (int i = 0; i < NC; i++)
      if (a >= BND[i] && a < BND[i+1]) return i;
    return -1;
  endfunction

  function automatic bit model_ready();
    int ch = route(in_addr);
    return (ch < 0) || (q[ch].size() < DEPTH);
  endfunction

  task automatic check_outputs();
    check("in_ready", in_ready, model_ready());
    for (int i = 0; i < NC; i++) begin
      logic [63:0] head;
      head = (q[i].size() != 0) ? q[i][0] : 64'h0;
      check($sformatf("ch%0d_valid", i), out_valid[i], q[i].size() != 0);
      check($sformatf("ch%0d_addr", i), out_addr[i*AB +: AB], head[63:32]);
      check($sformatf("ch%0d_data", i), out_data[i*DB +: DB], head[31:0]);
    end
`ifdef WRITE_CONFIG_ROUTER_DEBUG_EN
    check("err_valid", err_valid, m_ev);
    check("err_addr", err_addr, m_ea);
    check("err_cnt", err_cnt, m_ec);
`else
    check("err_valid", err_valid, 0);
    check("err_addr", err_addr, 0);
    check("err_cnt", err_cnt, 0);
`endif
  endtask

  // Applies one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    int ch;
    bit rdy;
    if (rst) return;
    ch  = route(in_addr);
    rdy = model_ready();
    for (int i = 0; i < NC; i++)
      if (q[i].size() != 0 && out_ready[i]) void'(q[i].pop_front());
    if (in_valid && rdy && ch >= 0)
      q[ch].push_back({in_addr - BND[ch], in_data});
    if (in_valid && ch < 0) begin
      m_ev = 1;
      m_ea = in_addr;
      m_ec = err_clear ? 1 : ((m_ec == (1 << CB) - 1) ? m_ec : m_ec + 1);
    end else if (err_clear) begin
      m_ev = 0; m_ea = '0; m_ec = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d);
    in_valid = v; in_addr = a; in_data = d;
  endtask

  initial begin
    int acc, t_acc;
    rst = 1'b1; err_clear = 1'b0; out_ready = '1;
    drive(0, 0, 0);
    m_ev = 0; m_ea = '0; m_ec = 0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_addr", out_addr, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Routing of a single write
    drive(1, 32'h234, 32'hDEAD);
    cycle();
    drive(0, 0, 0);
    check("route_valid", out_valid, 4'b0010);
    check("route_addr", out_addr[63:32], 32'h34);
    check("route_data", out_data[63:32], 32'hDEAD);
    cycle();
    check("route_drained", out_valid, 0);

    // Backpressure and fill on channel 2
    out_ready = 4'b1011;
    t_acc = -1;
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h300 + k, k);
      acc = 0;
      for (int t = 0; t < 20; t++) begin
        if (k == 4 && t == 2) out_ready[2] = 1'b1;
        #1;
        acc = in_ready;
        if (k == 4 && t == 0) check("bp_fifth_stalled", acc, 0);
        cycle();
        if (acc) begin
          if (k == 4) t_acc = t;
          break;
        end
      end
      check("bp_accept_timeout", acc, 1);
    end
    check("bp_fifth_after_pop", t_acc, 3);
    drive(0, 0, 0);
    repeat (6) cycle();

    // Simultaneous push and pop on channel 0
    out_ready = '0;
    drive(1, 32'h100, 32'hA0); cycle();
    drive(1, 32'h101, 32'hA1); cycle();
    out_ready[0] = 1'b1;
    drive(1, 32'h180, 32'hA2); cycle();
    check("pp_head", out_addr[31:0], 32'h1);
    drive(0, 0, 0);
    out_ready = '1;
    repeat (4) cycle();

    // Out-of-range writes, clear, saturation
    drive(1, 32'h0FF, 32'h1); cycle();
    drive(1, 32'h500, 32'h2); cycle();
    drive(0, 0, 0); cycle();
    check("oor_no_valid", out_valid, 0);
`ifdef WRITE_CONFIG_ROUTER_DEBUG_EN
    check("oor_cnt", err_cnt, 2);
    check("oor_addr", err_addr, 32'h500);
    check("oor_valid", err_valid, 1);
`endif
    err_clear = 1'b1; drive(1, 32'h050, 32'h3); cycle();
    err_clear = 1'b0; drive(0, 0, 0); cycle();
`ifdef WRITE_CONFIG_ROUTER_DEBUG_EN
    check("clr_drop_cnt", err_cnt, 1);
    check("clr_drop_addr", err_addr, 32'h50);
`endif
    err_clear = 1'b1; cycle(); err_clear = 1'b0;
    for (int k = 0; k < 5; k++) begin drive(1, 32'h600 + k, k); cycle(); end
    drive(0, 0, 0); cycle();
`ifdef WRITE_CONFIG_ROUTER_DEBUG_EN
    check("sat_cnt", err_cnt, 3);
`endif

    // Reset mid-stream with channel 3 holding entries
    out_ready = 4'b0111;
    for (int k = 0; k < 3; k++) begin drive(1, 32'h400 + k, 32'hB0 + k); cycle(); end
    drive(0, 0, 0);
    check("pre_rst_valid3", out_valid[3], 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_addr", out_addr, 0);
    for (int i = 0; i < NC; i++) q[i].delete();
    m_ev = 0; m_ea = '0; m_ec = 0;
    @(posedge clk); #1 rst = 1'b0;
    out_ready = '1;
    drive(1, 32'h400, 32'h77); cycle();
    drive(0, 0, 0);
    check("post_rst_valid", out_valid, 4'b1000);
    check("post_rst_addr", out_addr[127:96], 0);
    check("post_rst_data", out_data[127:96], 32'h77);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 9);
      in_valid = ($urandom_range(0, 3) != 0);
      if (r == 0)      in_addr = $urandom_range(0, 'hFF);
      else if (r == 1) in_addr = $urandom_range('h500, 'h5FF);
      else             in_addr = $urandom_range('h100, 'h4FF);
      in_data = $urandom;
      for (int i = 0; i < NC; i++) out_ready[i] = ($urandom_range(0, 9) < 6);
      err_clear = ($urandom_range(0, 15) == 0);
      cycle();
    end
    drive(0, 0, 0); err_clear = 1'b0; out_ready = '1;
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/write_config_router.md
# write_config_router

Parametrised successor to the single-cycle write-config splitter. Routes one stream of register writes (address, data) to `NUM_CONFIGS` downstream config channels by address-space bounds, rebasing each address to its channel's window. Adds valid/ready backpressure on every port, a per-channel FWFT FIFO, a non-zero base address, and defined handling of out-of-range writes. Sits between the host AXI-Lite write decoder and the per-module config register files.

## Interface

Parameters:
- `NUM_CONFIGS`, 4, number of output channels (≥1).
- `ADDR_BITS`, 32, address width.
- `DATA_BITS`, 32, write data width.
- `ADDR_SPACE_BOUNDS[NUM_CONFIGS+1]`, none, window edges.
  - Strictly increasing; `[0]` may be non-zero.
  - Channel i owns `[BOUNDS[i], BOUNDS[i+1])`.
- `FIFO_DEPTH`, 4, entries per channel; power of two, ≥2.
- `CNT_BITS`, 16, drop-counter width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `in_valid`  in  1  write request valid.
- `in_ready`  out  1  request accepted when high with `in_valid`.
- `in_addr`  in  ADDR_BITS  absolute address.
- `in_data`  in  DATA_BITS  write data.
- `out_valid`  out  NUM_CONFIGS  per-channel valid.
- `out_ready`  in  NUM_CONFIGS  per-channel ready.
- `out_addr`  out  NUM_CONFIGS*ADDR_BITS  rebased address; channel i at `[i*ADDR_BITS +: ADDR_BITS]`.
- `out_data`  out  NUM_CONFIGS*DATA_BITS  data; channel i at `[i*DATA_BITS +: DATA_BITS]`.
- `err_valid`  out  1  sticky, at least one write was dropped (debug only).
- `err_addr`  out  ADDR_BITS  address of the most recent dropped write (debug only).
- `err_cnt`  out  CNT_BITS  saturating count of dropped writes (debug only).
- `err_clear`  in  1  synchronous clear of the `err_*` outputs (debug only).

## Operation

- **Decode:** combinational on `in_addr`.
  - `hit[i] = (in_addr >= BOUNDS[i]) && (in_addr < BOUNDS[i+1])`; at most one bit set.
  - `oor = !(|hit)`.
- **Ready:** `in_ready = oor || !full[target]`.
  - Depends only on state and `in_addr`, never on `in_valid`.
  - A same-cycle pop does not free a slot for a push.
- **Accept** (`in_valid && in_ready`), hit case: push `{in_addr - BOUNDS[target], in_data}` into FIFO `target`.
  - Subtraction is modulo 2^ADDR_BITS; the result is always < window size.
- **Accept, out-of-range case:** the write is consumed (never stalls) and discarded. With the debug feature, error state updates.
- **FIFO** (per channel): occupancy counter 0..FIFO_DEPTH, read/write pointers `log2(FIFO_DEPTH)` bits wide, wrapping naturally.
  - `full = (cnt == FIFO_DEPTH)`.
  - `out_valid[i] = (cnt != 0)`; head entry presented FWFT.
  - Pop on `out_valid[i] && out_ready[i]`.
  - Push and pop in the same cycle leave `cnt` unchanged.
- **Ordering:**
  - Writes to the same channel leave in acceptance order.
  - There is no ordering guarantee across channels.
  - A full channel stalls all input: head-of-line blocking is intended.
- **Error state:**
  - On a drop: `err_valid<=1`, `err_addr<=in_addr`, `err_cnt<=err_cnt+1`, saturating at all-ones.
  - `err_clear` alone zeroes all three.
  - `err_clear` together with a drop yields `err_valid=1`, `err_addr=` the new address, `err_cnt=1`.

## Timing

- **Reset:** asynchronous assert, synchronous release by the environment. While `rst` is high, all FIFOs are empty and `out_valid=0`, `out_addr=0`, `out_data=0`, `err_valid=0`, `err_addr=0`, `err_cnt=0`. `in_ready` follows its combinational definition with empty FIFOs, so it is 1.
- **Reset mid-operation:** all queued writes are lost; no partial output.
- **Latency:** write accepted at edge N is visible on `out_*` in the cycle after edge N, i.e. one cycle, when its FIFO was empty.
- **Throughput:** one accepted write per cycle. Each channel sustains one pop per cycle.
- **Output stability:** `out_addr`/`out_data` of a channel hold stable while `out_valid[i] && !out_ready[i]`.
- **Error timing:** `err_*` update on the edge after the dropping handshake.

## Configuration

- Macro `WRITE_CONFIG_ROUTER_DEBUG_EN`.
- **Defined:**
  - `err_valid`/`err_addr`/`err_cnt` are implemented as above.
  - A simulation-only assertion flags `in_valid && oor` as `$error` (non-fatal).
- **Undefined:**
  - The error registers are not instantiated; `err_valid`, `err_addr` and `err_cnt` are tied to 0.
  - `err_clear` is ignored.
  - Out-of-range writes are still accepted and dropped silently.

## Test plan

- **Routing, single write:** BOUNDS={0x100,0x200,0x300,0x400,0x500}; write addr 0x234, data 0xDEAD, all `out_ready=1` → next cycle only `out_valid[1]=1`, `out_addr[1]=0x034`, `out_data[1]=0xDEAD`; one cycle later `out_valid=0`.
- **Backpressure and fill:** `out_ready[2]=0`; 5 back-to-back writes to 0x300..0x304, FIFO_DEPTH=4 → first 4 accepted, `in_ready=0` on the 5th. Then `out_ready[2]=1` → offsets 0,1,2,3 emerge in order, and the 5th is accepted the cycle after the first pop.
- **Simultaneous push/pop:** channel 0 holds 2 entries with `out_ready[0]=1`; write to 0x180 → occupancy stays 2 and the order is preserved.
- **Out-of-range:** writes to 0x0FF and 0x500 with DEBUG_EN → both accepted, no `out_valid`, `err_cnt=2`, `err_addr=0x500`, `err_valid=1`. `err_clear` with a drop of 0x050 in the same cycle → `err_cnt=1`, `err_addr=0x050`.
- **Saturation:** with CNT_BITS=2, 5 drops → `err_cnt=3`.
- **Reset mid-stream:** channel 3 holds 3 entries; pulse `rst` → `out_valid=0` immediately (asynchronous). After release, a write to 0x400 emerges alone with `out_addr=0`.
